// File: rtl/icache_arb_pkg.sv
// icache_arb_pkg: shared FSM state type and default sizing for the icache miss arbiter.
package icache_arb_pkg;
  typedef enum logic {IDLE, SEND} state_e;
  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_BA_BITS  = 7;
  localparam int DEF_WID_BITS = 2;
  localparam int DEF_NUM_TAG  = 4;
  localparam int DEF_TAG_BITS = 2;
endpackage

// File: rtl/icache_rr_arb.sv
// icache_rr_arb: round-robin pick of the first requester at or after ptr.
module icache_rr_arb #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        idx = W'((int'(ptr) + i) % N);
        any = 1'b1;
      end
    end
    gnt[idx] = any;
  end
endmodule

// File: rtl/icache_miss_arb.sv
// icache_miss_arb: arbitrates icache MSHR misses onto one memory port with tagged,
// out-of-order responses routed back to the originating requester.
module icache_miss_arb
  import icache_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int BA_BITS  = DEF_BA_BITS,
  parameter int WID_BITS = DEF_WID_BITS,
  parameter int NUM_TAG  = DEF_NUM_TAG,
  parameter int TAG_BITS = DEF_TAG_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*BA_BITS-1:0]   req_block_addr_i,
  input  logic [NUM_REQ*WID_BITS-1:0]  req_instr_id_i,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [BA_BITS-1:0]           mem_req_block_addr_o,
  output logic [TAG_BITS-1:0]          mem_req_tag_o,
  input  logic                         mem_rsp_valid_i,
  output logic                         mem_rsp_ready_o,
  input  logic [TAG_BITS-1:0]          mem_rsp_tag_i,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  output logic [BA_BITS-1:0]           rsp_block_addr_o,
  output logic [WID_BITS-1:0]          rsp_instr_id_o,
  output logic                         tag_err_o
);
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NT = 1 << TAG_BITS;
  state_e state_q, state_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [NT-1:0] tv_q, tv_d;
  logic [SW-1:0] tsrc_q [NT], tsrc_d [NT];
  logic [BA_BITS-1:0] taddr_q [NT], taddr_d [NT];
  logic [WID_BITS-1:0] tid_q [NT], tid_d [NT];
  logic [BA_BITS-1:0] addr_q, addr_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic err_q, err_d;
  logic [NUM_REQ-1:0] gnt;
  logic [SW-1:0] win, src;
  logic any, has_free, grant, hit, rsp_fire;
  logic [TAG_BITS-1:0] free_tag;
  icache_rr_arb #(.N(NUM_REQ), .W(SW)) u_rr (
    .req(req_valid_i),
    .ptr(rr_q),
    .gnt(gnt),
    .idx(win),
    .any(any)
  );
  // Free-tag search sees only registered state, so a tag freed this cycle waits a cycle.
  always_comb begin
    free_tag = '0;
    has_free = 1'b0;
    for (int t = NUM_TAG - 1; t >= 0; t--) begin
      if (!tv_q[t]) begin
        free_tag = TAG_BITS'(t);
        has_free = 1'b1;
      end
    end
  end
  assign grant                = (state_q == IDLE) && any && has_free;
  assign req_ready_o          = grant ? gnt : '0;
  assign mem_req_valid_o      = state_q == SEND;
  assign mem_req_block_addr_o = addr_q;
  assign mem_req_tag_o        = tag_q;
  assign src                  = tsrc_q[mem_rsp_tag_i];
  assign hit                  = tv_q[mem_rsp_tag_i];
  assign rsp_valid_o          = (mem_rsp_valid_i && hit) ? NUM_REQ'(1) << src : '0;
  assign mem_rsp_ready_o      = hit ? rsp_ready_i[src] : mem_rsp_valid_i;
  assign rsp_fire             = mem_rsp_valid_i && hit && rsp_ready_i[src];
  assign rsp_block_addr_o     = taddr_q[mem_rsp_tag_i];
  assign rsp_instr_id_o       = tid_q[mem_rsp_tag_i];
  assign tag_err_o            = err_q;
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    tv_d    = tv_q;
    tsrc_d  = tsrc_q;
    taddr_d = taddr_q;
    tid_d   = tid_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    err_d   = err_q | (mem_rsp_valid_i && !hit);
    if (rsp_fire) tv_d[mem_rsp_tag_i] = 1'b0;
    if (grant) begin
      tv_d[free_tag]    = 1'b1;
      tsrc_d[free_tag]  = win;
      taddr_d[free_tag] = req_block_addr_i[int'(win)*BA_BITS +: BA_BITS];
      tid_d[free_tag]   = req_instr_id_i[int'(win)*WID_BITS +: WID_BITS];
      addr_d            = req_block_addr_i[int'(win)*BA_BITS +: BA_BITS];
      tag_d             = free_tag;
      rr_d              = (win == SW'(NUM_REQ - 1)) ? '0 : win + SW'(1);
      state_d           = SEND;
    end else if (state_q == SEND && mem_req_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      tv_q    <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      tv_q    <= tv_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    tsrc_q  <= tsrc_d;
    taddr_q <= taddr_d;
    tid_q   <= tid_d;
  end
endmodule

// File: tb/tb_icache_miss_arb.sv
// tb_icache_miss_arb: directed scenarios plus randomized traffic, checked by a
// transaction-level model of grants, tag table and response routing.
module tb_icache_miss_arb;
  localparam int N = 4, BA = 7, WB = 2, NT = 4, TB = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N*BA-1:0] req_block_addr_i;
  logic [N*WB-1:0] req_instr_id_i;
  logic mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_ready_o, tag_err_o;
  logic [BA-1:0] mem_req_block_addr_o, rsp_block_addr_o;
  logic [TB-1:0] mem_req_tag_o, mem_rsp_tag_i;
  logic [WB-1:0] rsp_instr_id_o;
  int checks = 0, errors = 0;

  icache_miss_arb #(.NUM_REQ(N), .BA_BITS(BA), .WID_BITS(WB), .NUM_TAG(NT), .TAG_BITS(TB)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_block_addr_i(req_block_addr_i), .req_instr_id_i(req_instr_id_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_block_addr_o(mem_req_block_addr_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o), .mem_rsp_tag_i(mem_rsp_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_block_addr_o(rsp_block_addr_o), .rsp_instr_id_o(rsp_instr_id_o), .tag_err_o(tag_err_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: outstanding slots, round-robin pointer, one pending memory request.
  typedef struct { logic [BA-1:0] addr; int tag; } mreq_t;
  mreq_t mem_q[$];
  int mem_out[$];
  bit m_send, m_err, m_busy[NT];
  int m_rr, m_src[NT];
  logic [BA-1:0] m_addr[NT];
  logic [WB-1:0] m_id[NT];
  bit taken[N];
  bit rsp_done;

  always @(negedge clk) begin
    int w, ft, k, t, s;
    if (rst) begin
      m_send = 0; m_err = 0; m_rr = 0;
      for (int i = 0; i < NT; i++) m_busy[i] = 0;
      mem_q.delete(); mem_out.delete();
    end else begin
      w = -1; ft = -1;
      for (int i = 0; i < NT; i++) if (!m_busy[i] && ft < 0) ft = i;
      if (!m_send && ft >= 0)
        for (int i = 0; i < N; i++) begin
          k = (m_rr + i) % N;
          if (req_valid_i[k] && w < 0) w = k;
        end
      chk("req_ready", req_ready_o, w >= 0 ? 32'(1) << w : 0);
      chk("mem_req_valid", mem_req_valid_o, m_send);
      chk("tag_err", tag_err_o, m_err);
      if (m_send && mem_q.size() > 0) begin
        chk("mem_req_addr", mem_req_block_addr_o, mem_q[0].addr);
        chk("mem_req_tag", mem_req_tag_o, mem_q[0].tag);
        if (mem_req_ready_i) begin
          void'(mem_q.pop_front());
          mem_out.push_back(int'(mem_req_tag_o));
          m_send = 0;
        end
      end
      if (mem_rsp_valid_i) begin
        t = int'(mem_rsp_tag_i);
        if (m_busy[t]) begin
          s = m_src[t];
          chk("rsp_valid", rsp_valid_o, 32'(1) << s);
          chk("mem_rsp_ready", mem_rsp_ready_o, rsp_ready_i[s]);
          chk("rsp_addr", rsp_block_addr_o, m_addr[t]);
          chk("rsp_id", rsp_instr_id_o, m_id[t]);
          if (rsp_ready_i[s]) m_busy[t] = 0;
        end else begin
          chk("rsp_valid_badtag", rsp_valid_o, 0);
          chk("mem_rsp_ready_badtag", mem_rsp_ready_o, 1);
          m_err = 1;
        end
        if (mem_rsp_ready_o) begin
          rsp_done = 1;
          for (int i = mem_out.size() - 1; i >= 0; i--) if (mem_out[i] == t) mem_out.delete(i);
        end
      end else chk("rsp_valid_idle", rsp_valid_o, 0);
      if (w >= 0) begin
        m_busy[ft] = 1; m_src[ft] = w;
        m_addr[ft] = req_block_addr_i[w*BA +: BA];
        m_id[ft] = req_instr_id_i[w*WB +: WB];
        mem_q.push_back('{addr: m_addr[ft], tag: ft});
        m_send = 1; m_rr = (w + 1) % N; taken[w] = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(input int cycles);
    for (int i = 0; i < N; i++) taken[i] = 0;
    rsp_done = 0; mem_rsp_valid_i = 0;
    repeat (cycles) begin
      tick();
      for (int k = 0; k < N; k++)
        if (taken[k] || !req_valid_i[k]) begin
          taken[k] = 0;
          req_valid_i[k] = 1'($urandom_range(0, 1));
          req_block_addr_i[k*BA +: BA] = BA'($urandom);
          req_instr_id_i[k*WB +: WB] = WB'($urandom);
        end
      mem_req_ready_i = 1'($urandom_range(0, 1));
      rsp_ready_i = N'($urandom_range(0, 15));
      if (rsp_done || !mem_rsp_valid_i) begin
        rsp_done = 0;
        if (mem_out.size() > 0 && $urandom_range(0, 1) == 1) begin
          mem_rsp_valid_i = 1;
          mem_rsp_tag_i = TB'(mem_out[$urandom_range(0, mem_out.size() - 1)]);
        end else begin
          mem_rsp_valid_i = 0;
          mem_rsp_tag_i = TB'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    tick(); rst = 1; req_valid_i = '0; mem_rsp_valid_i = 0;
    tick(); rst = 0;
  endtask

  initial begin
    req_valid_i = '0; mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_tag_i = '0; rsp_ready_i = '0;
    for (int k = 0; k < N; k++) begin
      req_block_addr_i[k*BA +: BA] = BA'(10 + k);
      req_instr_id_i[k*WB +: WB] = WB'(k);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_mem_valid", mem_req_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_mem_rsp_ready", mem_rsp_ready_o, 0);
    chk("rst_tag_err", tag_err_o, 0);
    chk("rst_out_reg", {mem_req_block_addr_o, mem_req_tag_o}, 0);
    // Four requesters all asking: in-order grants every other cycle.
    tick(); req_valid_i = 4'b1111; mem_req_ready_i = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c % 2 == 0) chk("rr_grant", req_ready_o, 32'(1) << (c / 2));
      else begin
        chk("rr_gap", req_ready_o, 0);
        chk("rr_tag", mem_req_tag_o, c / 2);
        chk("rr_addr", mem_req_block_addr_o, 10 + c / 2);
      end
    end
    @(negedge clk);
    chk("full_no_grant", req_ready_o, 0);
    // Tags exhausted: requester 2 waits for a freed tag, which is usable one cycle later.
    tick(); req_valid_i = 4'b0100;
    repeat (3) begin @(negedge clk); chk("full_wait", req_ready_o, 0); end
    tick(); mem_rsp_valid_i = 1; mem_rsp_tag_i = 2'd1; rsp_ready_i = 4'b1111; mem_req_ready_i = 0;
    @(negedge clk);
    chk("free_rsp_valid", rsp_valid_o, 4'b0010);
    chk("free_same_cycle", req_ready_o, 0);
    tick(); mem_rsp_valid_i = 0;
    @(negedge clk);
    chk("free_next_grant", req_ready_o, 4'b0100);
    // Memory stalls for five cycles while in SEND.
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", mem_req_valid_o, 1);
      chk("stall_tag", mem_req_tag_o, 1);
      chk("stall_addr", mem_req_block_addr_o, 12);
      chk("stall_ready", req_ready_o, 0);
    end
    tick(); mem_req_ready_i = 1; req_valid_i = '0;
    tick();
    @(negedge clk);
    chk("stall_done", mem_req_valid_o, 0);
    // Out-of-order responses with one cycle of backpressure.
    tick(); mem_rsp_valid_i = 1; mem_rsp_tag_i = 2'd2; rsp_ready_i = 4'b1011;
    @(negedge clk);
    chk("bp_mem_rsp_ready", mem_rsp_ready_o, 0);
    chk("bp_rsp_valid", rsp_valid_o, 4'b0100);
    tick(); rsp_ready_i = 4'b1111;
    @(negedge clk);
    chk("ooo_t2_ready", mem_rsp_ready_o, 1);
    chk("ooo_t2_route", rsp_valid_o, 4'b0100);
    chk("ooo_t2_addr", rsp_block_addr_o, 12);
    tick(); mem_rsp_tag_i = 2'd0;
    @(negedge clk);
    chk("ooo_t0_route", rsp_valid_o, 4'b0001);
    chk("ooo_t0_addr", rsp_block_addr_o, 10);
    chk("ooo_t0_id", rsp_instr_id_o, 0);
    // Tag 3 returned, then returned again while unallocated.
    tick(); mem_rsp_tag_i = 2'd3;
    @(negedge clk);
    chk("t3_route", rsp_valid_o, 4'b1000);
    tick();
    @(negedge clk);
    chk("bad_mem_rsp_ready", mem_rsp_ready_o, 1);
    chk("bad_rsp_valid", rsp_valid_o, 0);
    tick(); mem_rsp_valid_i = 0;
    repeat (3) begin @(negedge clk); chk("err_sticky", tag_err_o, 1); end
    // Reset during SEND with two tags outstanding.
    do_reset();
    req_valid_i = 4'b0011; mem_req_ready_i = 1;
    @(negedge clk); chk("rs_grant0", req_ready_o, 4'b0001);
    @(negedge clk);
    @(negedge clk); chk("rs_grant1", req_ready_o, 4'b0010);
    tick(); mem_req_ready_i = 0; req_valid_i = '0;
    @(negedge clk); chk("rs_in_send", mem_req_valid_o, 1);
    tick(); rst = 1;
    tick(); rst = 0; req_valid_i = 4'b1111; mem_req_ready_i = 1;
    @(negedge clk);
    chk("rs_valid_dropped", mem_req_valid_o, 0);
    chk("rs_ptr_zero", req_ready_o, 4'b0001);
    chk("rs_err_clear", tag_err_o, 0);
    @(negedge clk); chk("rs_tag0_free", mem_req_tag_o, 0);
    @(negedge clk); chk("rs_next", req_ready_o, 4'b0010);
    @(negedge clk); chk("rs_tag1_free", mem_req_tag_o, 1);
    do_reset();
    rand_phase(3000);
    do_reset();
    rand_phase(3000);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
